// File: rtl/oled_spi_driver_pkg.sv
// Shared state encodings, command ROMs and frame constants for the SSD1306 SPI driver.
package oled_spi_driver_pkg;

  localparam int unsigned INIT_LEN    = 25;
  localparam int unsigned ADDR_LEN    = 6;
  localparam int unsigned FRAME_BYTES = 1024;

  typedef enum logic [2:0] {
    PANEL_RST = 3'd0,
    INIT      = 3'd1,
    ADDR      = 3'd2,
    FETCH     = 3'd3,
    SHIFT     = 3'd4,
    NEXT      = 3'd5
  } drv_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2,
    TX_TAIL = 2'd3
  } tx_state_e;

  // SSD1306 power-up command sequence, sent once after panel reset.
  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'hD5;
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;
      5'd4:  b = 8'h3F;
      5'd5:  b = 8'hD3;
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;
      5'd11: b = 8'h00;
      5'd12: b = 8'hA1;
      5'd13: b = 8'hC8;
      5'd14: b = 8'hDA;
      5'd15: b = 8'h12;
      5'd16: b = 8'h81;
      5'd17: b = 8'hCF;
      5'd18: b = 8'hD9;
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;
      5'd23: b = 8'hA6;
      5'd24: b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Full-screen column/page address window, re-sent at the start of every frame.
  function automatic logic [7:0] addr_rom(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0: b = 8'h21;
      3'd1: b = 8'h00;
      3'd2: b = 8'h7F;
      3'd3: b = 8'h22;
      3'd4: b = 8'h00;
      3'd5: b = 8'h07;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_spi_driver_spi_byte_tx.sv
// One-byte SPI mode-0 transmitter: SCLK divider, MSB-first shifter and CS/DC framing.
module spi_byte_tx
  import oled_spi_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  output logic       dc_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  // CS falls on the last low cycle of bit 7, i.e. one cycle before the first rising edge.
  localparam logic [CNT_W-1:0] CS_AT = CNT_W'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);
  localparam bit CS_AT_LOAD = (CLK_DIV == 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             dc_q, dc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and pin registers; reset parks the bus idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Bit sequencing: MOSI updates on load and on SCLK falling edges only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          state_d = TX_LOW;
          cnt_d   = '0;
          bit_d   = 3'd7;
          shreg_d = byte_i;
          mosi_d  = byte_i[7];
          dc_d    = dc_i;
          busy_d  = 1'b1;
          if (CS_AT_LOAD) cs_n_d = 1'b0;
        end
      end
      TX_LOW: begin
        if (!CS_AT_LOAD && (bit_q == 3'd7) && (cnt_q == CS_AT)) cs_n_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = TX_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_HIGH: begin
        if (cnt_q == CNT_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == 3'd0) begin
            state_d = TX_TAIL;
          end else begin
            bit_d   = bit_q - 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
            mosi_d  = shreg_q[6];
            state_d = TX_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_TAIL: begin
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign cs_n_o = cs_n_q;
  assign dc_o   = dc_q;

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 frame streamer: panel reset, init ROM, then endless address window + 1024 pixel bytes.
module oled_spi_driver
  import oled_spi_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RST_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] byte_counter,
  input  logic [7:0] data_to_send,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       oled_dc,
  output logic       oled_rst_n,
  output logic       frame_done
);

  localparam int unsigned RST_CNT_W = $clog2(2 * RST_CYCLES + 1);
  localparam logic [RST_CNT_W-1:0] RST_HI_AT = RST_CNT_W'(RST_CYCLES);
  // INIT is entered early enough that the first CS fall lands RST_CYCLES after panel reset release.
  localparam logic [RST_CNT_W-1:0] INIT_AT =
    RST_CNT_W'((RST_CYCLES > CLK_DIV) ? (2 * RST_CYCLES - CLK_DIV) : RST_CYCLES);
  localparam logic [4:0] INIT_LAST  = 5'(INIT_LEN - 1);
  localparam logic [4:0] ADDR_LAST  = 5'(ADDR_LEN - 1);
  localparam logic [9:0] FRAME_LAST = 10'(FRAME_BYTES - 1);

  drv_state_e           state_q, state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [4:0]           idx_q, idx_d;
  logic [9:0]           byte_counter_q, byte_counter_d;
  logic                 fetch_q, fetch_d;
  logic                 wait_q, wait_d;
  logic                 oled_rst_n_q, oled_rst_n_d;
  logic                 frame_done_q, frame_done_d;

  logic                 start_c;
  logic [7:0]           tx_byte_c;
  logic                 tx_dc_c;
  logic                 tx_busy;
  logic                 tx_done;

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PANEL_RST;
      rst_cnt_q      <= '0;
      idx_q          <= '0;
      byte_counter_q <= '0;
      fetch_q        <= 1'b0;
      wait_q         <= 1'b0;
      oled_rst_n_q   <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      idx_q          <= idx_d;
      byte_counter_q <= byte_counter_d;
      fetch_q        <= fetch_d;
      wait_q         <= wait_d;
      oled_rst_n_q   <= oled_rst_n_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next-state logic; each command byte is launched once and then awaited via tx_done.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    idx_d          = idx_q;
    byte_counter_d = byte_counter_q;
    fetch_d        = fetch_q;
    wait_d         = wait_q;
    oled_rst_n_d   = oled_rst_n_q;
    frame_done_d   = 1'b0;
    start_c        = 1'b0;
    tx_byte_c      = 8'h00;
    tx_dc_c        = 1'b0;
    unique case (state_q)
      PANEL_RST: begin
        rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        if (rst_cnt_q == RST_HI_AT) oled_rst_n_d = 1'b1;
        if (rst_cnt_q == INIT_AT) begin
          oled_rst_n_d = 1'b1;
          rst_cnt_d    = '0;
          idx_d        = '0;
          wait_d       = 1'b0;
          state_d      = INIT;
        end
      end
      INIT: begin
        tx_byte_c = init_rom(idx_q);
        if (!wait_q) begin
          if (!tx_busy) begin
            start_c = 1'b1;
            wait_d  = 1'b1;
          end
        end else if (tx_done) begin
          wait_d = 1'b0;
          if (idx_q == INIT_LAST) begin
            idx_d   = '0;
            state_d = ADDR;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ADDR: begin
        tx_byte_c = addr_rom(idx_q[2:0]);
        if (!wait_q) begin
          if (!tx_busy) begin
            start_c = 1'b1;
            wait_d  = 1'b1;
          end
        end else if (tx_done) begin
          wait_d = 1'b0;
          if (idx_q == ADDR_LAST) begin
            idx_d          = '0;
            byte_counter_d = '0;
            fetch_d        = 1'b0;
            state_d        = FETCH;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      FETCH: begin
        // Second cycle: the controller's registered byte is valid and goes straight into the shifter.
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else if (!tx_busy) begin
          tx_byte_c = data_to_send;
          tx_dc_c   = 1'b1;
          start_c   = 1'b1;
          fetch_d   = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tx_done) state_d = NEXT;
      end
      NEXT: begin
        if (byte_counter_q == FRAME_LAST) begin
          frame_done_d   = 1'b1;
          byte_counter_d = '0;
          idx_d          = '0;
          wait_d         = 1'b0;
          state_d        = ADDR;
        end else begin
          byte_counter_d = byte_counter_q + 10'd1;
          fetch_d        = 1'b0;
          state_d        = FETCH;
        end
      end
      default: state_d = PANEL_RST;
    endcase
  end

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_c),
    .byte_i  (tx_byte_c),
    .dc_i    (tx_dc_c),
    .busy_o  (tx_busy),
    .done_o  (tx_done),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .cs_n_o  (spi_cs_n),
    .dc_o    (oled_dc)
  );

  assign byte_counter = byte_counter_q;
  assign oled_rst_n   = oled_rst_n_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Directed bench: SPI byte decoder plus a linear sequence of reset, init, frame and abort checks.
module tb_oled_spi_driver;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 10;
  localparam int HDR        = 31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] byte_counter;
  logic [7:0] data_to_send = 8'h00;
  logic       spi_sclk, spi_mosi, spi_cs_n, oled_dc, oled_rst_n, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] hdr_exp [HDR] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF,
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  oled_spi_driver #(
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_counter (byte_counter),
    .data_to_send (data_to_send),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .oled_dc      (oled_dc),
    .oled_rst_n   (oled_rst_n),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Image controller model: registered byte_counter[7:0], one cycle late.
  always @(posedge clk) data_to_send <= byte_counter[7:0];

  // SPI decoder; entries are {dc, byte_counter at CS fall, byte}.
  logic [18:0] mon_q [$];
  int   mosi_err = 0, len_err = 0, dc_err = 0, abort_cnt = 0;
  int   min_gap = 1000, fd_pulses = 0, fd_hi = 0, fd_qsize = -1;
  int   bits = 0, low_len = 0, hi_len = 0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, p_fd = 1'b0;
  logic [7:0] sh = 8'h00;
  logic       b_dc = 1'b0;
  logic [9:0] b_bc = 10'd0;

  // Samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bits    = 0;
      low_len = 0;
      hi_len  = 0;
    end else begin
      if ((oled_dc !== p_dc) && (!spi_cs_n || !p_cs)) dc_err++;
      if (!spi_cs_n) begin
        if (p_cs) begin
          bits    = 0;
          low_len = 1;
          b_dc    = oled_dc;
          b_bc    = byte_counter;
          if (hi_len < min_gap) min_gap = hi_len;
        end else begin
          low_len++;
        end
      end
      if (spi_sclk && !p_sclk) begin
        if (spi_mosi !== p_mosi) mosi_err++;
        sh = {sh[6:0], spi_mosi};
        bits++;
      end
      if (spi_sclk && p_sclk && (spi_mosi !== p_mosi)) mosi_err++;
      if (spi_cs_n && !p_cs) begin
        if (bits == 8) begin
          mon_q.push_back({b_dc, b_bc, sh});
          if (low_len != 16 * CLK_DIV) len_err++;
        end else begin
          abort_cnt++;
        end
        hi_len = 1;
      end else if (spi_cs_n) begin
        hi_len++;
      end
      if (frame_done) begin
        fd_hi++;
        if (!p_fd) begin
          fd_pulses++;
          fd_qsize = mon_q.size();
        end
      end
    end
    p_cs   = spi_cs_n;
    p_sclk = spi_sclk;
    p_mosi = spi_mosi;
    p_dc   = oled_dc;
    p_fd   = frame_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while ((mon_q.size() < n) && (c < budget)) begin
      @(posedge clk);
      c++;
    end
    if (mon_q.size() < n) begin
      check("timeout_bytes", 32'(mon_q.size()), 32'(n));
      finish_test();
    end
  endtask

  // Measures panel-reset low time and the delay to the first CS fall after rst_n release.
  task automatic check_reset_release(input string tag);
    int lo = 0;
    int gap = 0;
    while ((oled_rst_n === 1'b0) && (lo < 200)) begin
      @(posedge clk);
      #1;
      if (oled_rst_n === 1'b0) lo++;
    end
    check({tag, "_oled_rst_low"}, 32'(lo), 32'(RST_CYCLES));
    while ((spi_cs_n === 1'b1) && (gap < 200)) begin
      @(posedge clk);
      #1;
      gap++;
    end
    check({tag, "_first_cs_gap"}, 32'(gap), 32'(RST_CYCLES));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, 32'(spi_sclk), 32'd0);
    check({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
    check({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
    check({tag, "_dc"}, 32'(oled_dc), 32'd0);
    check({tag, "_oled_rst_n"}, 32'(oled_rst_n), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_byte_counter"}, 32'(byte_counter), 32'd0);
  endtask

  initial begin
    int qs;
    int c;
    logic [18:0] e;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    check_reset_release("por");

    // Init ROM followed by the address window, all commands.
    wait_bytes(HDR, 5000);
    e = mon_q[0];
    check("first_byte", {23'd0, e[18], e[7:0]}, {23'd0, 1'b0, 8'hAE});
    for (int i = 0; i < HDR; i++) begin
      e = mon_q[i];
      check($sformatf("hdr_%0d", i), {23'd0, e[18], e[7:0]}, {23'd0, 1'b0, hdr_exp[i]});
    end

    // One full frame, then the re-sent address window and first pixel of the next frame.
    wait_bytes(HDR + 1024 + 6 + 1, 60000);
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] idx;
      idx = 10'(i);
      check($sformatf("pix_%0d", i), 32'(mon_q[HDR + i]), {13'd0, 1'b1, idx, idx[7:0]});
    end
    check("frame_done_pulses", 32'(fd_pulses), 32'd1);
    check("frame_done_width", 32'(fd_hi), 32'd1);
    check("frame_done_pos", 32'(fd_qsize), 32'(HDR + 1024));
    for (int i = 0; i < 6; i++) begin
      e = mon_q[HDR + 1024 + i];
      check($sformatf("readdr_%0d", i), {23'd0, e[18], e[7:0]}, {23'd0, 1'b0, hdr_exp[25 + i]});
    end
    check("frame2_pix0", 32'(mon_q[HDR + 1024 + 6]), {13'd0, 1'b1, 10'd0, 8'h00});

    // Bus timing collected by the decoder so far.
    check("mosi_stable", 32'(mosi_err), 32'd0);
    check("cs_low_len", 32'(len_err), 32'd0);
    check("dc_under_cs", 32'(dc_err), 32'd0);
    check("no_partial", 32'(abort_cnt), 32'd0);
    check("cs_high_gap", 32'(min_gap >= 1), 32'd1);

    // Abort pixel byte 500 of frame two with sclk high and mosi set.
    c = 0;
    while (!((byte_counter == 10'd500) && (spi_cs_n === 1'b0)) && (c < 30000)) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("reach_byte_500", 32'(byte_counter), 32'd500);
    qs = mon_q.size();
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_release("rerun");
    wait_bytes(qs + 1, 2000);
    check("last_before_rst", 32'(mon_q[qs - 1]), {13'd0, 1'b1, 10'd499, 8'hF3});
    e = mon_q[qs];
    check("restart_first_byte", {23'd0, e[18], e[7:0]}, {23'd0, 1'b0, 8'hAE});
    check("restart_no_frame_done", 32'(fd_pulses), 32'd1);
    finish_test();
  end

endmodule

// File: doc/oled_spi_driver.md
OLED_SPI_DRIVER -- requirements
Module: oled_spi_driver

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, giving system-clock cycles per SCLK half-period (minimum 1).
REQ-002 The module SHALL have parameter RST_CYCLES, default 1000, giving the number of cycles oled_rst_n is held low after reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port byte_counter, output, 10 bits: the frame-buffer byte index (0..1023) presented to the image controller.
REQ-006 The module SHALL have port data_to_send, input, 8 bits: the pixel byte from the image controller, registered, valid 1 cycle after byte_counter.
REQ-007 The module SHALL have port spi_sclk, output, 1 bit: SPI clock, mode 0, idle low.
REQ-008 The module SHALL have port spi_mosi, output, 1 bit: SPI data, MSB first.
REQ-009 The module SHALL have port spi_cs_n, output, 1 bit: chip select, active low.
REQ-010 The module SHALL have port oled_dc, output, 1 bit: data/command select, 0 for command and 1 for pixel data.
REQ-011 The module SHALL have port oled_rst_n, output, 1 bit: panel hardware reset, active low.
REQ-012 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the last byte of each frame.

Function
REQ-013 The FSM SHALL have states PANEL_RST, INIT, ADDR, FETCH, SHIFT, NEXT.
- PANEL_RST holds oled_rst_n=0 for RST_CYCLES, then drives it 1 and waits another RST_CYCLES before entering INIT.
REQ-014 INIT SHALL send the 25-byte SSD1306 init ROM with oled_dc=0.
- ROM contents in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
REQ-015 ADDR SHALL send the 6 command bytes 21 00 7F 22 00 07 with oled_dc=0, then set byte_counter=0 and enter FETCH.
REQ-016 FETCH SHALL hold byte_counter stable for 2 cycles and capture data_to_send into the shift register on the second cycle.
- This covers the controller's 1-cycle registered latency.
REQ-017 SHIFT SHALL transmit 8 bits MSB first in SPI mode 0.
- spi_mosi changes only while spi_sclk is low.
- Each bit has spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles, so one byte takes 16*CLK_DIV cycles.
- oled_dc is 1 for pixel bytes.
REQ-018 spi_cs_n SHALL go low one cycle before the first SCLK edge of each byte.
- It returns high one cycle after the final SCLK falling edge.
- It stays high for at least 1 cycle between bytes.
REQ-019 NEXT SHALL act on byte_counter as follows:
- If byte_counter<1023: increment byte_counter and enter FETCH.
- If byte_counter==1023: pulse frame_done for 1 cycle, wrap byte_counter to 0, and enter ADDR. Every frame therefore re-sends the address window and INIT is never repeated.
REQ-020 oled_dc SHALL change only while spi_cs_n is high.
REQ-021 A change in data_to_send outside the FETCH capture cycle SHALL NOT affect a byte in flight.

Reset
REQ-022 Asserting rst_n=0 at any time, including mid-byte or mid-frame, SHALL take effect immediately and asynchronously.
- State goes to PANEL_RST; byte_counter=0.
- spi_sclk=0, spi_mosi=0, spi_cs_n=1, oled_dc=0, oled_rst_n=0, frame_done=0.
- All internal counters are cleared.
REQ-023 After rst_n is released, the full PANEL_RST → INIT → ADDR sequence SHALL repeat before any pixel byte is sent.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the INIT ROM contents, INIT_LEN=25, the ADDR command bytes, ADDR_LEN=6, and FRAME_BYTES=1024.
REQ-025 A sub-module spi_byte_tx SHALL contain the SCLK divider and 8-bit shifter.
- Inputs: start, byte, dc.
- Outputs: busy, done, and the SPI pins.
- The FSM in oled_spi_driver sequences it.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, using CLK_DIV=2 and RST_CYCLES=10 unless stated otherwise:
- Reset release → oled_rst_n low for 10 cycles, then high; first CS-low occurs 10 cycles later; the decoded first byte is 0xAE with dc=0.
- Init sequence → the SPI monitor decodes exactly the 25 init bytes and then the 6 address bytes, all with dc=0, in order.
- data_to_send model returning byte_counter[7:0] with 1-cycle latency → pixel bytes 00,01,…,FF,00,… with dc=1 and no skipped or duplicated index.
- End of frame → after byte index 1023, frame_done pulses exactly once; the next bytes are 21 00 7F 22 00 07 with dc=0; byte_counter restarts at 0.
- Timing at CLK_DIV=2 → each byte spans 32 cycles of SCLK activity; MOSI is stable across every SCLK rising edge; at least 1 CS-high cycle between bytes.
- rst_n asserted mid-SHIFT of byte 500 → all outputs take their reset values in the same cycle; after release, the sequence restarts from PANEL_RST and no partial byte is completed.
